fetch_stage: RTL and testbench

//  Instruction fetch stage. Owns the PC, issues one-outstanding reads to instruction memory and holds
//  the fetched word in an IF/ID register that feeds the decoder/control unit (if_opcode -> opcode input).

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC ownership, one outstanding imem read,
// an IF/ID register towards decode and a one-entry hold buffer used when
// decode stalls while a read is still in flight.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | request at pc driven, waiting for imem_req_ready
// S_WAIT  | one read outstanding; r_drop marks it stale after a redirect
// S_HOLD  | read returned while IF/ID was full; word parked in hold buffer
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [6:0]  if_opcode
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_drop;
    logic        r_started;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic        w_accept;
    logic        w_slot_free;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_next_pc;

    // Request only goes out from the first edge after reset release onward.
    assign imem_req_valid = r_started && (r_state == S_FETCH);
    assign imem_addr      = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;
    assign w_slot_free    = !r_if_valid || id_ready;
    assign w_redirect_pc  = redirect_pc & ~32'd3;
    assign w_next_pc      = r_req_pc + 32'd4;

    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_opcode = r_if_instr[6:0];

    // Fetch FSM, PC, IF/ID register and hold buffer; redirect wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC & ~32'd3;
            r_req_pc     <= 32'd0;
            r_drop       <= 1'b0;
            r_started    <= 1'b0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= NOP_INSTR;
            r_if_pc      <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
        end else begin
            r_started <= 1'b1;
            if (redirect) begin
                r_if_valid   <= 1'b0;
                r_if_instr   <= NOP_INSTR;
                r_hold_instr <= 32'd0;
                r_hold_pc    <= 32'd0;
                r_pc         <= w_redirect_pc;
                case (r_state)
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            r_state <= S_FETCH;
                            r_drop  <= 1'b0;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        if (w_accept) begin
                            // The read just issued belongs to the old path.
                            r_state  <= S_WAIT;
                            r_drop   <= 1'b1;
                            r_req_pc <= r_pc;
                        end else begin
                            r_drop   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_FETCH;
                        r_drop  <= 1'b0;
                    end
                endcase
            end else begin
                // Decode consumption; overridden below when a new word lands.
                if (id_ready && r_if_valid) begin
                    r_if_valid <= 1'b0;
                    r_if_instr <= NOP_INSTR;
                end
                case (r_state)
                    S_FETCH: begin
                        if (w_accept) begin
                            r_state  <= S_WAIT;
                            r_req_pc <= r_pc;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= S_FETCH;
                            end else if (w_slot_free) begin
                                r_if_valid <= 1'b1;
                                r_if_instr <= imem_rsp_data;
                                r_if_pc    <= r_req_pc;
                                r_pc       <= w_next_pc;
                                r_state    <= S_FETCH;
                            end else begin
                                r_hold_instr <= imem_rsp_data;
                                r_hold_pc    <= r_req_pc;
                                r_pc         <= w_next_pc;
                                r_state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (id_ready) begin
                            r_if_valid <= 1'b1;
                            r_if_instr <= r_hold_instr;
                            r_if_pc    <= r_hold_pc;
                            r_state    <= S_FETCH;
                        end
                    end
                    default: begin
                        r_state <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model of the fetch pipeline,
// a memory responder with programmable latency, directed scenarios with
// literal expectations, and a second instance exercising PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [6:0]  if_opcode;

    int checks = 0;
    int errors = 0;
    int rsp_delay = 1;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_opcode(if_opcode)
    );

    // Second instance starting at the top of the address space.
    logic        w2_req_valid;
    logic [31:0] w2_addr;
    logic        w2_rsp_valid = 1'b0;
    logic [31:0] w2_rsp_data = 32'd0;
    logic        w2_one = 1'b1;
    logic        w2_zero = 1'b0;
    logic [31:0] w2_zpc = 32'd0;
    logic        w2_if_valid;
    logic [31:0] w2_if_instr;
    logic [31:0] w2_if_pc;
    logic [6:0]  w2_if_opcode;
    logic [31:0] w2_reqs[$];

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w2_req_valid), .imem_req_ready(w2_one),
        .imem_addr(w2_addr), .imem_rsp_valid(w2_rsp_valid),
        .imem_rsp_data(w2_rsp_data), .redirect(w2_zero),
        .redirect_pc(w2_zpc), .id_ready(w2_one),
        .if_valid(w2_if_valid), .if_instr(w2_if_instr), .if_pc(w2_if_pc),
        .if_opcode(w2_if_opcode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory for the main instance: answers each accepted read after rsp_delay cycles.
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'd0;
    always @(posedge clk) begin
        if (imem_rsp_valid) pend = 1'b0;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            pend  = 1'b1;
            pcnt  = rsp_delay;
            paddr = imem_addr;
        end else if (pend) begin
            pcnt = pcnt - 1;
        end
        #1;
        imem_rsp_valid = pend && (pcnt == 1);
        imem_rsp_data  = imem_rsp_valid ? mem_word(paddr) : 32'hDEAD_BEEF;
    end

    // Memory for the wrap instance: one-cycle response, records request addresses.
    always @(posedge clk) begin
        logic        acc;
        logic [31:0] a;
        acc = rst_n && w2_req_valid;
        a   = w2_addr;
        #1;
        w2_rsp_valid = acc;
        w2_rsp_data  = mem_word(a);
        if (acc && w2_reqs.size() < 3) w2_reqs.push_back(a);
    end

    // Reference model: pending fetched words as a queue (front = IF/ID),
    // plus whether a read is in flight and whether it is stale.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t        m_q[$];
    logic        m_started = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_req_pc = 32'd0;
    logic [31:0] m_last_pc = 32'd0;

    function automatic logic m_req();
        return m_started && !m_busy && (m_q.size() < 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_started = 1'b0;
            m_busy    = 1'b0;
            m_stale   = 1'b0;
            m_pc      = 32'd0;
            m_req_pc  = 32'd0;
            m_last_pc = 32'd0;
        end else begin
            acc = m_req() && imem_req_ready;
            if (redirect) begin
                m_q.delete();
                m_pc = redirect_pc & ~32'd3;
                if (m_busy) begin
                    if (imem_rsp_valid) begin
                        m_busy  = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end else if (acc) begin
                    m_busy  = 1'b1;
                    m_stale = 1'b1;
                end
            end else begin
                if (id_ready && m_q.size() > 0) void'(m_q.pop_front());
                if (m_busy && imem_rsp_valid) begin
                    m_busy = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        e.pc    = m_req_pc;
                        e.instr = mem_word(m_req_pc);
                        m_q.push_back(e);
                        m_pc = m_req_pc + 32'd4;
                    end
                end else if (acc) begin
                    m_busy   = 1'b1;
                    m_req_pc = m_pc;
                end
            end
            if (m_q.size() > 0) m_last_pc = m_q[0].pc;
            m_started = 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ei;
        ev = m_q.size() > 0;
        ei = ev ? m_q[0].instr : NOP;
        chk("m_req_valid", {31'd0, imem_req_valid}, {31'd0, m_req()});
        if (m_req()) chk("m_imem_addr", imem_addr, m_pc);
        chk("m_if_valid", {31'd0, if_valid}, {31'd0, ev});
        chk("m_if_instr", if_instr, ei);
        chk("m_if_pc", if_pc, m_last_pc);
        chk("m_if_opcode", {25'd0, if_opcode}, {25'd0, ei[6:0]});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        rsp_delay = 1;
        cyc(2);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;

        // T1: straight-line fetch, one instruction every two cycles
        cyc(1);
        chk("t1_first_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t1_first_addr", imem_addr, 32'h0);
        cyc(1);
        chk("t1_not_yet_valid", {31'd0, if_valid}, 32'd0);
        cyc(1);
        w = mem_word(32'h0);
        chk("t1_valid0", {31'd0, if_valid}, 32'd1);
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_opcode0", {25'd0, if_opcode}, {25'd0, w[6:0]});
        cyc(2);
        chk("t1_pc4", if_pc, 32'h4);
        cyc(2);
        chk("t1_pc8", if_pc, 32'h8);

        // T2: decode stall: pc 8 held in IF/ID, pc 12 parked in hold buffer
        id_ready = 1'b0;
        cyc(6);
        chk("t2_hold_pc", if_pc, 32'h8);
        chk("t2_hold_instr", if_instr, mem_word(32'h8));
        chk("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
        id_ready = 1'b1;
        cyc(1);
        chk("t2_buf_pc", if_pc, 32'hC);
        chk("t2_buf_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_next_addr", imem_addr, 32'h10);
        cyc(2);
        chk("t2_pc16", if_pc, 32'h10);

        // T3: redirect while a slow read is outstanding
        rsp_delay = 3;
        cyc(1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc(1);
        redirect = 1'b0;
        chk("t3_flush_valid", {31'd0, if_valid}, 32'd0);
        cyc(2);
        chk("t3_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_addr", imem_addr, 32'h100);
        rsp_delay = 1;
        cyc(2);
        chk("t3_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_pc", if_pc, 32'h100);

        // T4: redirect together with a response and a decode consume
        id_ready = 1'b0;
        cyc(1);
        chk("t4_waiting", {31'd0, imem_req_valid}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        id_ready = 1'b1;
        cyc(1);
        redirect = 1'b0;
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_instr", if_instr, NOP);
        chk("t4_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t4_addr", imem_addr, 32'h200);
        cyc(2);
        chk("t4_pc", if_pc, 32'h200);

        // T6: asynchronous reset in the middle of an outstanding read
        id_ready = 1'b0;
        rsp_delay = 3;
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_async_instr", if_instr, NOP);
        chk("t6_async_pc", if_pc, 32'd0);
        chk("t6_async_req", {31'd0, imem_req_valid}, 32'd0);
        cyc(1);
        rst_n = 1'b1;
        rsp_delay = 1;
        cyc(1);
        chk("t6_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_addr", imem_addr, 32'h0);
        cyc(2);
        chk("t6_valid", {31'd0, if_valid}, 32'd1);
        chk("t6_pc", if_pc, 32'h0);
        chk("t6_instr", if_instr, mem_word(32'h0));
        cyc(4);

        // T5: PC wrap from the top of the address space
        chk("t5_nreq", w2_reqs.size(), 32'd3);
        if (w2_reqs.size() >= 3) begin
            chk("t5_addr0", w2_reqs[0], 32'hFFFF_FFFC);
            chk("t5_addr1", w2_reqs[1], 32'h0000_0000);
            chk("t5_addr2", w2_reqs[2], 32'h0000_0004);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog timeout t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
